opcode_fetch: RTL and testbench

OPCODE_FETCH -- requirements
Module: opcode_fetch

---
 rtl/opcode_fetch_pkg.sv | 15 +
 rtl/opcode_fifo.sv | 49 ++++
 rtl/opcode_fetch.sv | 102 ++++++++++
 tb/tb_opcode_fetch.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opcode_fetch_pkg.sv
// Opcode fetch shared types and defaults.
// FIFO entry pairs an opcode byte with its byte address.
package opcode_fetch_pkg;

  localparam int          OF_FIFO_DEPTH = 4;
  localparam logic [31:0] OF_RESET_PC   = 32'h0;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] pc;
  } of_entry_t;

  localparam int OF_ENTRY_W = $bits(of_entry_t);

endpackage

// File: rtl/opcode_fifo.sv
// Prefetch FIFO for opcode bytes.
// Power-of-two depth so the pointers wrap on their own.
module opcode_fifo
  import opcode_fetch_pkg::*;
#(
  parameter int  DEPTH = OF_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [OF_ENTRY_W-1:0] wdata_i,
  output logic [CW-1:0]         count_o,
  output logic [OF_ENTRY_W-1:0] head_o
);

  logic [OF_ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]         rd_q;
  logic [AW-1:0]         wr_q;
  logic [CW-1:0]         cnt_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/opcode_fetch.sv
// Opcode prefetch: one-outstanding byte fetcher
// feeding a small FIFO, with kill/redirect.
module opcode_fetch
  import opcode_fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = OF_FIFO_DEPTH,
  parameter logic [31:0] RESET_PC   = OF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        if__req,
  output logic [31:0] if__addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_data,
  output logic [7:0]  opcode,
  output logic [31:0] opcode_pc,
  input  logic        mc__more_2a,
  output logic        mc__stall,
  input  logic        kill_4a,
  input  logic [31:0] redirect_pc_4a
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_q, pc_d;
  logic        disc_q, disc_d;

  logic                  hold;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nx;
  logic [OF_ENTRY_W-1:0] head;
  of_entry_t             head_e;
  of_entry_t             wr_e;

  assign empty = (cnt == '0);
  assign hold  = req_q && !imem_ack;
  assign push  = req_q && imem_ack && !disc_q && !kill_4a;
  assign pop   = !mc__more_2a && !empty && !kill_4a;

  assign cnt_nx = kill_4a ? '0
                : cnt + CW'(push) - CW'(pop);

  // pc_q is the next address to issue; addr_q
  // freezes while a request waits for its ack.
  always_comb begin
    pc_d   = pc_q;
    disc_d = disc_q;
    if (kill_4a) begin
      pc_d   = redirect_pc_4a;
      disc_d = hold;
    end else if (req_q && imem_ack) begin
      disc_d = 1'b0;
      if (!disc_q) pc_d = pc_q + 32'd1;
    end
    req_d  = hold || (cnt_nx < DEPTH_C);
    addr_d = hold ? addr_q : pc_d;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
      pc_q   <= RESET_PC;
      disc_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      pc_q   <= pc_d;
      disc_q <= disc_d;
    end
  end

  assign wr_e.op = imem_data;
  assign wr_e.pc = addr_q;

  opcode_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (kill_4a),
    .wdata_i (wr_e),
    .count_o (cnt),
    .head_o  (head)
  );

  assign head_e    = of_entry_t'(head);
  assign if__req   = req_q;
  assign if__addr  = addr_q;
  assign opcode    = empty ? 8'h00 : head_e.op;
  assign opcode_pc = empty ? 32'h0 : head_e.pc;
  assign mc__stall = !mc__more_2a && empty;

endmodule

// File: tb/tb_opcode_fetch.sv
// Bench for opcode_fetch: directed vectors, kill
// corner cases and random traffic vs a queue model.
module tb_opcode_fetch;
  import opcode_fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        if__req;
  logic [31:0] if__addr;
  logic        imem_ack = 1'b0;
  logic [7:0]  imem_data = 8'h00;
  logic [7:0]  opcode;
  logic [31:0] opcode_pc;
  logic        mc__more_2a = 1'b0;
  logic        mc__stall;
  logic        kill_4a = 1'b0;
  logic [31:0] redirect_pc_4a = 32'h0;

  always #5 clk = ~clk;

  opcode_fetch #(
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RPC)
  ) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .if__req        (if__req),
    .if__addr       (if__addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .opcode         (opcode),
    .opcode_pc      (opcode_pc),
    .mc__more_2a    (mc__more_2a),
    .mc__stall      (mc__stall),
    .kill_4a        (kill_4a),
    .redirect_pc_4a (redirect_pc_4a)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [7:0] op_of(
    logic [31:0] a);
    return a[7:0] + 8'h10;
  endfunction

  // Reference model: FIFO as a queue, one request
  // slot, a discard flag and the next fetch pc.
  typedef struct {
    logic [7:0]  op;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] cons[$];
  bit          m_out;
  bit          m_disc;
  logic [31:0] m_addr;
  logic [31:0] m_pc;
  int          lat;
  int          wcnt;
  bit          smp_stall;

  task automatic model_reset();
    mq.delete();
    cons.delete();
    m_out  = 1'b0;
    m_disc = 1'b0;
    m_pc   = RPC;
    m_addr = RPC;
    wcnt   = 0;
  endtask

  task automatic check_outs(string t);
    bit e_st;
    e_st = !mc__more_2a && (mq.size() == 0);
    chk({t, ".req"}, 32'(if__req), 32'(m_out));
    if (m_out) chk({t, ".addr"}, if__addr, m_addr);
    chk({t, ".op"}, 32'(opcode),
        mq.size() > 0 ? 32'(mq[0].op) : 32'h0);
    chk({t, ".pc"}, opcode_pc,
        mq.size() > 0 ? mq[0].pc : 32'h0);
    chk({t, ".stall"}, 32'(mc__stall), 32'(e_st));
  endtask

  task automatic model_edge(bit more, bit kill,
                            logic [31:0] rpc,
                            bit ack);
    bit acked;
    ent_t e;
    acked = m_out && ack;
    if (kill) begin
      mq.delete();
      m_pc   = rpc;
      m_disc = m_out && !ack;
      if (acked) m_out = 1'b0;
    end else begin
      if (!more && mq.size() > 0) begin
        e = mq.pop_front();
        cons.push_back(e.pc);
      end
      if (acked) begin
        if (!m_disc) begin
          e.op = op_of(m_addr);
          e.pc = m_addr;
          mq.push_back(e);
          m_pc = m_addr + 32'd1;
        end
        m_disc = 1'b0;
        m_out  = 1'b0;
      end
    end
    if (!m_out && mq.size() < DEPTH) begin
      m_out  = 1'b1;
      m_addr = m_pc;
    end
  endtask

  // Called at a negedge; returns at the next one.
  task automatic step(bit more, bit kill,
                      logic [31:0] rpc);
    bit r;
    bit a;
    mc__more_2a    = more;
    kill_4a        = kill;
    redirect_pc_4a = rpc;
    a = if__req && (wcnt >= lat);
    imem_ack  = a;
    imem_data = a ? op_of(if__addr) : 8'h00;
    #1;
    r = if__req;
    smp_stall = mc__stall;
    check_outs("cyc");
    @(posedge clk);
    model_edge(more, kill, rpc, a);
    if (!r || a) wcnt = 0;
    else wcnt++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_b          = 1'b0;
    mc__more_2a    = 1'b0;
    kill_4a        = 1'b0;
    imem_ack       = 1'b0;
    imem_data      = 8'h00;
    redirect_pc_4a = 32'h0;
    #1;
    model_reset();
    chk("rst.req", 32'(if__req), 32'h0);
    chk("rst.addr", if__addr, RPC);
    chk("rst.op", 32'(opcode), 32'h0);
    chk("rst.pc", opcode_pc, 32'h0);
    chk("rst.stall", 32'(mc__stall), 32'h1);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  typedef struct {
    bit          more;
    bit          ack;
    logic [7:0]  data;
    bit          e_req;
    logic [31:0] e_addr;
    logic [7:0]  e_op;
    logic [31:0] e_pc;
    bit          e_stall;
  } vec_t;

  vec_t tv[9];

  initial begin
    logic [6:0] sseq;
    bit got;
    int guard;

    tv[0] = '{1, 0, 8'h00, 0, 32'h0, 8'h00, 32'h0, 0};
    tv[1] = '{1, 1, 8'h10, 1, 32'h0, 8'h00, 32'h0, 0};
    tv[2] = '{1, 1, 8'h11, 1, 32'h1, 8'h10, 32'h0, 0};
    tv[3] = '{1, 1, 8'h12, 1, 32'h2, 8'h10, 32'h0, 0};
    tv[4] = '{1, 1, 8'h13, 1, 32'h3, 8'h10, 32'h0, 0};
    tv[5] = '{1, 0, 8'h00, 0, 32'h4, 8'h10, 32'h0, 0};
    tv[6] = '{0, 0, 8'h00, 0, 32'h4, 8'h10, 32'h0, 0};
    tv[7] = '{1, 1, 8'h14, 1, 32'h4, 8'h11, 32'h1, 0};
    tv[8] = '{1, 0, 8'h00, 0, 32'h4, 8'h11, 32'h1, 0};

    lat = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset release, fill with stalled sequencer.
    for (int i = 0; i < 9; i++) begin
      mc__more_2a = tv[i].more;
      imem_ack    = tv[i].ack;
      imem_data   = tv[i].data;
      kill_4a     = 1'b0;
      #1;
      chk($sformatf("tv%0d.req", i),
          32'(if__req), 32'(tv[i].e_req));
      if (tv[i].e_req)
        chk($sformatf("tv%0d.addr", i),
            if__addr, tv[i].e_addr);
      chk($sformatf("tv%0d.op", i),
          32'(opcode), 32'(tv[i].e_op));
      chk($sformatf("tv%0d.pc", i),
          opcode_pc, tv[i].e_pc);
      chk($sformatf("tv%0d.stall", i),
          32'(mc__stall), 32'(tv[i].e_stall));
      @(negedge clk);
    end
    imem_ack = 1'b0;

    // Empty FIFO with 3-cycle memory latency.
    do_reset();
    lat = 3;
    sseq = '0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 32'h0);
      sseq[6-i] = smp_stall;
    end
    chk("lat3.stall_seq", 32'(sseq), 32'h7D);

    // Kill while request at 5 is outstanding.
    do_reset();
    lat = 2;
    guard = 0;
    while (!(if__req && if__addr == 32'h5 &&
             wcnt == 0) && guard < 60) begin
      step(1'b0, 1'b0, 32'h0);
      guard++;
    end
    chk("k1.reach5", 32'(guard < 60), 32'h1);
    step(1'b0, 1'b1, 32'h200);
    cons.delete();
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!got && if__req && if__addr != 32'h5) begin
        chk("k1.next_addr", if__addr, 32'h200);
        got = 1'b1;
      end
      step(1'b0, 1'b0, 32'h0);
    end
    chk("k1.redirected", 32'(got), 32'h1);
    chk("k1.first_pc",
        cons.size() > 0 ? cons[0] : 32'hDEAD,
        32'h200);

    // Kill coincident with ack and pop.
    do_reset();
    lat = 0;
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 32'h0);
    mc__more_2a = 1'b0;
    #1;
    chk("k2.pre_nonempty", 32'(mc__stall), 32'h0);
    chk("k2.pre_req", 32'(if__req), 32'h1);
    step(1'b0, 1'b1, 32'h300);
    #1;
    chk("k2.empty", 32'(mc__stall), 32'h1);
    chk("k2.req", 32'(if__req), 32'h1);
    chk("k2.addr", if__addr, 32'h300);
    cons.delete();
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 32'h0);
    chk("k2.first_pc",
        cons.size() > 0 ? cons[0] : 32'hDEAD,
        32'h300);

    // Address wrap at the top of memory.
    step(1'b0, 1'b1, 32'hFFFF_FFFE);
    cons.delete();
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 32'h0);
    chk("wrap.n", 32'(cons.size() >= 3), 32'h1);
    if (cons.size() >= 3) begin
      chk("wrap.pc0", cons[0], 32'hFFFF_FFFE);
      chk("wrap.pc1", cons[1], 32'hFFFF_FFFF);
      chk("wrap.pc2", cons[2], 32'h0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      bit kl;
      if (i == 1500) do_reset();
      if (wcnt == 0) lat = $urandom_range(0, 3);
      kl  = ($urandom_range(0, 24) == 0);
      rpc = ($urandom_range(0, 1) == 0) ? $urandom()
          : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), kl, rpc);
      if (cons.size() > 64) cons.delete();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
